alu_arbiter: RTL

Shares one instance of the team's 32-bit ALU between two requesters, e.g. the execute stage (requester 0) and the multdiv/branch helper unit (requester 1).
- Arbitration is round-robin with valid/ready handshakes.
- Accepted operands are latched and pushed through the ALU in one cycle.
- Result and flags are held on a shared response port until the consumer accepts them.
- One operation is outstanding at a time.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu.sv | 56 +++++
 rtl/rr_arb2.sv | 35 +++
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// datapath widths, opcode constants, FSM state encoding and the
// operand bundle captured at the request handshake.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int OPC_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int ID_W    = 1;

    localparam logic [OPC_W-1:0] ALU_ADD = 5'd0;
    localparam logic [OPC_W-1:0] ALU_SUB = 5'd1;
    localparam logic [OPC_W-1:0] ALU_AND = 5'd2;
    localparam logic [OPC_W-1:0] ALU_OR  = 5'd3;
    localparam logic [OPC_W-1:0] ALU_SLL = 5'd4;
    localparam logic [OPC_W-1:0] ALU_SRA = 5'd5;

    // Arbiter sequencing: accept, compute, present
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One accepted operation as it sits in the operand registers
    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [OPC_W-1:0]   opcode;
        logic [SHAMT_W-1:0] shamt;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: add, sub, and, or, sll, sra.
// Comparison flags (ne, lt) are produced for every opcode; overflow is
// reported only for add and sub. Unknown opcodes yield a zero result.
module alu
    import alu_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    output logic [DATA_W-1:0]  result,
    output logic               ne,
    output logic               lt,
    output logic               ovf
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;

    assign sum  = a + b;
    assign diff = a - b;

    // Overflow: operands of like sign (add) or unlike sign (sub) whose
    // result sign differs from A.
    assign add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
    assign sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);

    assign ne = (a != b);
    // Signed less-than: sign of the difference corrected by overflow
    assign lt = diff[DATA_W-1] ^ sub_ovf;

    // Opcode decode selects the result and the overflow source
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        result = '0;
        ovf    = 1'b0;
        case (opcode)
            ALU_ADD: begin
                result = sum;
                ovf    = add_ovf;
            end
            ALU_SUB: begin
                result = diff;
                ovf    = sub_ovf;
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLL: result = a << shamt;
            ALU_SRA: result = $unsigned($signed(a) >>> shamt);
            default: ;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational; a single
// pointer flop records which requester wins a tie and is moved to the
// other requester whenever a grant is taken (update high).
module rr_arb2 #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       update,
    output logic [1:0] grant
);

    logic ptr;

    // A lone requester always wins; on contention the pointer decides
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // After a grant, favour the requester that did not win
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignment so all flops
        // sample pre-edge values regardless of block ordering.
        if (reset) begin
            ptr <= RESET_PRIO;
        end else if (update) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with valid/ready handshakes.
// IDLE accepts the round-robin winner, EXEC registers the ALU output,
// RESP holds the response until the consumer takes it. One operation
// is in flight at a time.
// Optional per-requester grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RESET_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [OPC_W-1:0]   req0_opcode,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [DATA_W-1:0]  req0_a,
    input  logic [DATA_W-1:0]  req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [OPC_W-1:0]   req1_opcode,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [DATA_W-1:0]  req1_a,
    input  logic [DATA_W-1:0]  req1_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic [DATA_W-1:0]  resp_result,
    output logic               resp_ne,
    output logic               resp_lt,
    output logic               resp_ovf,
    output logic               busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   grant_cnt0,
    output logic [CNT_W-1:0]   grant_cnt1
`endif
);

    state_t            state;
    state_t            state_next;
    logic [1:0]        req_valid;
    logic [1:0]        grant;
    logic              handshake;
    alu_op_t           req0_op;
    alu_op_t           req1_op;
    alu_op_t           op_q;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ne;
    logic              alu_lt;
    logic              alu_ovf;

    assign req_valid = {req1_valid, req0_valid};
    // A grant is only taken while waiting for work
    assign handshake = (state == IDLE) && (req_valid != 2'b00);

    assign req0_op = '{id: 1'b0, opcode: req0_opcode, shamt: req0_shamt, a: req0_a, b: req0_b};
    assign req1_op = '{id: 1'b1, opcode: req1_opcode, shamt: req1_shamt, a: req1_a, b: req1_b};

    rr_arb2 #(
        .RESET_PRIO (RESET_PRIO != 0)
    ) u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  (req_valid),
        .update (handshake),
        .grant  (grant)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept -> compute -> present until consumed
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake)  state_next = EXEC;
            EXEC:                    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
            end
            EXEC: busy = 1'b1;
            RESP: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand registers capture the winning request on the handshake edge
    always_ff @(posedge clock) begin
        // NOTE: pure datapath, no reset: it is only read in EXEC, which is
        // reachable solely through a load, so reset adds nothing.
        if (handshake) begin
            op_q <= grant[1] ? req1_op : req0_op;
        end
    end

    alu u_alu (
        .opcode (op_q.opcode),
        .shamt  (op_q.shamt),
        .a      (op_q.a),
        .b      (op_q.b),
        .result (alu_result),
        .ne     (alu_ne),
        .lt     (alu_lt),
        .ovf    (alu_ovf)
    );

    // Response registers load once in EXEC and hold through RESP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_id     <= '0;
            resp_result <= '0;
            resp_ne     <= 1'b0;
            resp_lt     <= 1'b0;
            resp_ovf    <= 1'b0;
        end else if (state == EXEC) begin
            resp_id     <= op_q.id;
            resp_result <= alu_result;
            resp_ne     <= alu_ne;
            resp_lt     <= alu_lt;
            resp_ovf    <= alu_ovf;
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester grant counters, wrapping at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (handshake) begin
            if (grant[0]) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (grant[1]) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end
`else
    // Counter width has no effect without the statistics counters
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
